// File: rtl/axil_dsram.sv
// axil_dsram: AXI-lite responder for the core's data memory.
// Word-addressed on-chip array with byte-lane writes and programmable
// response latency. Read and write channels run independent FSMs and each
// allows one outstanding transaction.
//
// Optional feature macro: DSRAM_RAND_LAT_EN
//   defined   -> an 8-bit LFSR adds 0..7 extra cycles to each transaction.
//   undefined -> fixed RD_LAT / WR_LAT.
module axil_dsram #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          DEPTH     = 4096,
  parameter int          RD_LAT    = 1,
  parameter int          WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 16;
  // 33-bit limit so a region ending at 4 GiB does not wrap to zero
  localparam logic [32:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);
  localparam logic [CW-1:0] RD_INIT = CW'(RD_LAT - 1);
  localparam logic [CW-1:0] WR_INIT = CW'(WR_LAT - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

  function automatic logic in_range(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, BASE_ADDR}) && ({1'b0, a} < ADDR_LIMIT);
  endfunction

  function automatic logic [AW-1:0] word_idx(input logic [31:0] a);
    return AW'((a - BASE_ADDR) >> 2);
  endfunction

  logic [31:0] mem [DEPTH];

  // extra latency cycles, sampled by each channel at its accepting handshake
  logic [2:0] lat_extra;

`ifdef DSRAM_RAND_LAT_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, free-running out of reset
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 8'hA5;
    else     lfsr_q <= lfsr_d;
  end

  assign lat_extra = lfsr_q[2:0];
`else
  assign lat_extra = 3'd0;
`endif

  // ---------------------------------------------------------------- read side
  r_state_e        r_state_q, r_state_d;
  logic [CW-1:0]   rcnt_q, rcnt_d;
  logic [AW-1:0]   ar_idx_q, ar_idx_d;
  logic            ar_ok_q, ar_ok_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;

  // read FSM: accept AR, count down latency, sample array, hold response
  always_comb begin
    r_state_d = r_state_q;
    rcnt_d    = rcnt_q;
    ar_idx_d  = ar_idx_q;
    ar_ok_d   = ar_ok_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          ar_idx_d  = word_idx(araddr);
          ar_ok_d   = in_range(araddr);
          rcnt_d    = RD_INIT + CW'(lat_extra);
          r_state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (rcnt_q == '0) begin
          rdata_d   = ar_ok_q ? mem[ar_idx_q] : 32'h0;
          rresp_d   = ar_ok_q ? RESP_OKAY : RESP_DECERR;
          r_state_d = R_RESP;
        end else begin
          rcnt_d = rcnt_q - 1'b1;
        end
      end
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // read channel registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rcnt_q    <= '0;
      ar_idx_q  <= '0;
      ar_ok_q   <= 1'b0;
      rdata_q   <= 32'h0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rcnt_q    <= rcnt_d;
      ar_idx_q  <= ar_idx_d;
      ar_ok_q   <= ar_ok_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;

  // --------------------------------------------------------------- write side
  w_state_e        w_state_q, w_state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            aw_got_q, aw_got_d;
  logic            w_got_q, w_got_d;
  logic [AW-1:0]   aw_idx_q, aw_idx_d;
  logic            aw_ok_q, aw_ok_d;
  logic [31:0]     wd_q, wd_d;
  logic [3:0]      ws_q, ws_d;
  logic [1:0]      bresp_q, bresp_d;
  logic            mem_we;

  // write FSM: collect AW and W in any order, count down, commit, respond
  always_comb begin
    w_state_d = w_state_q;
    wcnt_d    = wcnt_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    aw_idx_d  = aw_idx_q;
    aw_ok_d   = aw_ok_q;
    wd_d      = wd_q;
    ws_d      = ws_q;
    bresp_d   = bresp_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        awready = !aw_got_q;
        wready  = !w_got_q;
        if (awvalid && !aw_got_q) begin
          aw_got_d = 1'b1;
          aw_idx_d = word_idx(awaddr);
          aw_ok_d  = in_range(awaddr);
        end
        if (wvalid && !w_got_q) begin
          w_got_d = 1'b1;
          wd_d    = wdata;
          ws_d    = wstrb;
        end
        if ((aw_got_q || awvalid) && (w_got_q || wvalid)) begin
          wcnt_d    = WR_INIT + CW'(lat_extra);
          w_state_d = W_WAIT;
        end
      end
      W_WAIT: begin
        if (wcnt_q == '0) begin
          mem_we    = aw_ok_q;
          bresp_d   = aw_ok_q ? RESP_OKAY : RESP_DECERR;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
          w_state_d = W_RESP;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // write channel registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      wcnt_q    <= '0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      aw_idx_q  <= '0;
      aw_ok_q   <= 1'b0;
      wd_q      <= 32'h0;
      ws_q      <= 4'h0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      wcnt_q    <= wcnt_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      aw_idx_q  <= aw_idx_d;
      aw_ok_q   <= aw_ok_d;
      wd_q      <= wd_d;
      ws_q      <= ws_d;
      bresp_q   <= bresp_d;
    end
  end

  assign bresp = bresp_q;

  // data array, byte-lane write; no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ws_q[i]) mem[aw_idx_q][8*i +: 8] <= wd_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_dsram.sv
// Directed bench for axil_dsram with default parameters (RD_LAT=WR_LAT=1).
module tb_axil_dsram;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int errors = 0;
  int checks = 0;

  axil_dsram dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full write transaction; starts just after a rising edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output int lat);
    int  n;
    logic aw_hs, w_hs;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    chk("wr_accept", {31'h0, awvalid | wvalid}, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (bvalid) break;
      @(posedge clk); #1;
      lat++;
    end
    resp = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  // Full read transaction; starts just after a rising edge.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d,
                         output logic [1:0] resp, output int lat);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (arvalid && n < 50) begin
      @(negedge clk);
      if (arready) begin
        @(posedge clk); #1;
        arvalid = 1'b0;
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    chk("rd_accept", {31'h0, arvalid}, 32'h0);
    arvalid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      if (rvalid) break;
      @(posedge clk); #1;
      lat++;
    end
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  logic [31:0] rd, rd2;
  logic [1:0]  rr, br, br2;
  int          lat, lat2;
  logic        seen;

  initial begin
    rst = 1'b1;
    araddr = 32'h8000_0010; arvalid = 1'b1; rready = 1'b0;
    awaddr = 32'h8000_0010; awvalid = 1'b1;
    wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;

    // reset values, with handshakes attempted during reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", {31'h0, arready}, 32'h1);
    chk("rst_awready", {31'h0, awready}, 32'h1);
    chk("rst_wready",  {31'h0, wready},  32'h1);
    chk("rst_rvalid",  {31'h0, rvalid},  32'h0);
    chk("rst_bvalid",  {31'h0, bvalid},  32'h0);
    chk("rst_rdata",   rdata,            32'h0);
    chk("rst_rresp",   {30'h0, rresp},   32'h0);
    chk("rst_bresp",   {30'h0, bresp},   32'h0);
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_idle", {28'h0, arready, awready, wready, rvalid | bvalid}, 32'hE);
    @(posedge clk); #1;

    // full write then read back, latency 1 both ways
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, br, lat);
    chk("wr1_bresp", {30'h0, br}, 32'h0);
    chk("wr1_lat", lat, 32'd1);
    do_read(32'h8000_0010, rd, rr, lat);
    chk("rd1_data", rd, 32'hDEAD_BEEF);
    chk("rd1_rresp", {30'h0, rr}, 32'h0);
    chk("rd1_lat", lat, 32'd1);

    // byte-lane partial write
    do_write(32'h8000_0010, 32'h0000_5500, 4'b0010, br, lat);
    chk("wr2_bresp", {30'h0, br}, 32'h0);
    do_read(32'h8000_0010, rd, rr, lat);
    chk("rd2_data", rd, 32'hDEAD_55EF);

    // wstrb=0 commits nothing but still answers OKAY
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, br, lat);
    chk("wr3_bresp", {30'h0, br}, 32'h0);
    do_read(32'h8000_0010, rd, rr, lat);
    chk("rd3_data", rd, 32'hDEAD_55EF);

    // W three cycles ahead of AW, then bready held low 5 cycles
    awaddr = 32'h8000_0020; wdata = 32'h1234_5678; wstrb = 4'hF;
    wvalid = 1'b1;
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_ready", {29'h0, awready, wready, bvalid}, 32'h4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    chk("wfirst_after_aw", {29'h0, awready, wready, bvalid}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("wfirst_bvalid_lat", {31'h0, bvalid}, 32'h1);
    chk("wfirst_bresp", {30'h0, bresp}, 32'h0);
    awaddr = 32'h8000_0024; wdata = 32'hFFFF_FFFF; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bhold_state", {28'h0, bvalid, awready, wready, 1'b0}, 32'h8);
      chk("bhold_bresp", {30'h0, bresp}, 32'h0);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("bhs_release", {29'h0, bvalid, awready, wready}, 32'h3);
    @(posedge clk); #1;
    do_read(32'h8000_0020, rd, rr, lat);
    chk("rd_wfirst", rd, 32'h1234_5678);

    // out-of-range read and write; OOR write would alias word 0
    do_write(32'h8000_0000, 32'hA5A5_0001, 4'hF, br, lat);
    do_read(32'h7FFF_FFFC, rd, rr, lat);
    chk("oor_rd_rresp", {30'h0, rr}, 32'h3);
    chk("oor_rd_rdata", rd, 32'h0);
    do_write(32'h8000_4000, 32'hFFFF_FFFF, 4'hF, br, lat);
    chk("oor_wr_bresp", {30'h0, br}, 32'h3);
    do_read(32'h8000_0000, rd, rr, lat);
    chk("oor_wr_nochange", rd, 32'hA5A5_0001);

    // last in-range word
    do_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, br, lat);
    chk("last_wr_bresp", {30'h0, br}, 32'h0);
    do_read(32'h8000_3FFF, rd, rr, lat);
    chk("last_rd_data", rd, 32'hCAFE_F00D);
    chk("last_rd_rresp", {30'h0, rr}, 32'h0);

    // rready held low 5 cycles, new AR presented meanwhile
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk); #1;
    araddr = 32'h8000_0020;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rhold_state", {30'h0, rvalid, arready}, 32'h2);
      chk("rhold_rdata", rdata, 32'hDEAD_55EF);
      @(posedge clk); #1;
    end
    @(negedge clk);
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("rhs_release", {30'h0, rvalid, arready}, 32'h1);
    @(posedge clk); #1;

    // same-edge read sample and write commit on one word
    do_write(32'h8000_0030, 32'h1111_1111, 4'hF, br, lat);
    fork
      do_read(32'h8000_0030, rd, rr, lat);
      do_write(32'h8000_0030, 32'h2222_2222, 4'hF, br2, lat2);
    join
    chk("rw_same_edge_old", rd, 32'h1111_1111);
    chk("rw_same_edge_lat", {lat[15:0], lat2[15:0]}, 32'h0001_0001);
    do_read(32'h8000_0030, rd, rr, lat);
    chk("rw_same_edge_new", rd, 32'h2222_2222);

    // reset during R_WAIT: no response, arready back high
    araddr = 32'h8000_0010; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_rwait_arready", {31'h0, arready}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | rvalid;
      @(posedge clk); #1;
    end
    chk("rst_rwait_no_rvalid", {31'h0, seen}, 32'h0);

    // reset during W_WAIT: uncommitted write dropped
    awaddr = 32'h8000_0010; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen = seen | bvalid;
      @(posedge clk); #1;
    end
    chk("rst_wwait_no_bvalid", {31'h0, seen}, 32'h0);
    do_read(32'h8000_0010, rd, rr, lat);
    chk("rst_retained", rd, 32'hDEAD_55EF);
    do_read(32'h8000_0020, rd2, rr, lat);
    chk("rst_retained2", rd2, 32'h1234_5678);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
